pim_matrix_loader: RTL and testbench

- Upstream feeder for the PIM matrix-multiply controller.
- Accepts a serial valid/ready stream of elements: all of matrix A row-major, then all of matrix B row-major.
- Assembles them into the flat arrays that the controller consumes.
- Pulses start once both matrices are complete, then stalls input until the controller reports result_ready, so the arrays stay stable for the whole computation. A watchdog recovers if result_ready never arrives.

---
 rtl/pim_matrix_loader.sv | 193 +++++++++++++++++++
 tb/tb_pim_matrix_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_matrix_loader.sv
// pim_matrix_loader: collects a serial element stream (A row-major, then B
// row-major) into flat arrays, fires a one-cycle start to the matrix-multiply
// controller and holds input off until the controller reports completion.
// A watchdog returns the loader to LOAD_A if result_ready never arrives.
module pim_matrix_loader #(
  parameter int WIDTH          = 16,
  parameter int MATRIX_SIZE    = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] matrix_A [MATRIX_SIZE*MATRIX_SIZE-1:0],
  output logic [WIDTH-1:0] matrix_B [MATRIX_SIZE*MATRIX_SIZE-1:0],
  output logic             start,
  input  logic             result_ready,
  output logic             busy,
  output logic             frame_error,
  output logic             timeout
);

  localparam int NN = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_FIRE   = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_next_idx;
  logic [WW-1:0]   r_wd;
  logic [WW-1:0]   w_next_wd;
  logic            w_xfer;
  logic            w_wr_a;
  logic            w_wr_b;
  logic            w_frame_err;
  logic            w_timeout;
  logic [WIDTH-1:0] r_matrix_a [NN-1:0];
  logic [WIDTH-1:0] r_matrix_b [NN-1:0];
  logic            r_start;
  logic            r_busy;
  logic            r_frame_error;
  logic            r_timeout;

  // Ready depends on state only so upstream never sees a valid->ready loop.
  assign in_ready = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign w_xfer   = in_valid && in_ready;

  assign matrix_A    = r_matrix_a;
  assign matrix_B    = r_matrix_b;
  assign start       = r_start;
  assign busy        = r_busy;
  assign frame_error = r_frame_error;
  assign timeout     = r_timeout;

  // State, element index and watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD_A;
      r_idx   <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_wd    <= w_next_wd;
    end
  end

  // Next-state, index/watchdog update and write/pulse decisions.
  // The watchdog already counts during FIRE so that timeout lands exactly
  // TIMEOUT_CYCLES cycles after start; it rests at zero while loading.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_wd    = r_wd;
    w_wr_a       = 1'b0;
    w_wr_b       = 1'b0;
    w_frame_err  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_LOAD_A: begin
        w_next_wd = '0;
        if (w_xfer) begin
          if (in_last) begin
            w_frame_err = 1'b1;
            w_next_idx  = '0;
          end else if (r_idx == LAST_IDX) begin
            w_wr_a       = 1'b1;
            w_next_idx   = '0;
            w_next_state = S_LOAD_B;
          end else begin
            w_wr_a     = 1'b1;
            w_next_idx = r_idx + IW'(1);
          end
        end else begin
          w_next_idx = r_idx;
        end
      end
      S_LOAD_B: begin
        w_next_wd = '0;
        if (w_xfer) begin
          if (r_idx == LAST_IDX) begin
            // Final B slot is written whether or not the frame closes cleanly.
            w_wr_b     = 1'b1;
            w_next_idx = '0;
            if (in_last) begin
              w_next_state = S_FIRE;
            end else begin
              w_frame_err  = 1'b1;
              w_next_state = S_LOAD_A;
            end
          end else if (in_last) begin
            w_frame_err  = 1'b1;
            w_next_idx   = '0;
            w_next_state = S_LOAD_A;
          end else begin
            w_wr_b     = 1'b1;
            w_next_idx = r_idx + IW'(1);
          end
        end else begin
          w_next_idx = r_idx;
        end
      end
      S_FIRE: begin
        w_next_wd    = r_wd + WW'(1);
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (result_ready) begin
          w_next_state = S_LOAD_A;
          w_next_idx   = '0;
          w_next_wd    = '0;
        end else if (r_wd == WD_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = S_LOAD_A;
          w_next_idx   = '0;
          w_next_wd    = '0;
        end else begin
          w_next_wd = r_wd + WW'(1);
        end
      end
      default: begin
        w_next_state = S_LOAD_A;
        w_next_idx   = '0;
        w_next_wd    = '0;
      end
    endcase
  end

  // Registered control outputs, derived from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_error <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_start       <= (w_next_state == S_FIRE);
      r_busy        <= (w_next_state == S_FIRE) || (w_next_state == S_WAIT);
      r_frame_error <= w_frame_err;
      r_timeout     <= w_timeout;
    end
  end

  // Matrix storage: each array changes only on its own accepted element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NN; i++) begin
        r_matrix_a[i] <= '0;
        r_matrix_b[i] <= '0;
      end
    end else begin
      if (w_wr_a) begin
        r_matrix_a[r_idx] <= in_data;
      end
      if (w_wr_b) begin
        r_matrix_b[r_idx] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pim_matrix_loader.sv
// Directed self-checking bench for pim_matrix_loader with N=2, WIDTH=16.
// dut uses a long watchdog; dut_t uses TIMEOUT_CYCLES=8 for watchdog tests.
module tb_pim_matrix_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = 16'd0;
  logic        in_valid = 1'b0, in_last = 1'b0, result_ready = 1'b0;
  logic        in_ready, start, busy, frame_error, timeout;
  logic [15:0] matrix_A [3:0];
  logic [15:0] matrix_B [3:0];
  logic        t_valid = 1'b0, t_last = 1'b0, t_rr = 1'b0;
  logic        t_in_ready, t_start, t_busy, t_frame_error, t_timeout;
  logic [15:0] t_matrix_A [3:0];
  logic [15:0] t_matrix_B [3:0];

  int tests = 0;
  int failed = 0;
  int start_cnt = 0;
  int fe_cnt = 0;
  int t_to_cnt = 0;

  pim_matrix_loader #(.WIDTH(16), .MATRIX_SIZE(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .matrix_A(matrix_A), .matrix_B(matrix_B),
    .start(start), .result_ready(result_ready), .busy(busy),
    .frame_error(frame_error), .timeout(timeout));

  pim_matrix_loader #(.WIDTH(16), .MATRIX_SIZE(2), .TIMEOUT_CYCLES(8)) dut_t (
    .clk(clk), .rst(rst), .in_valid(t_valid), .in_ready(t_in_ready),
    .in_data(in_data), .in_last(t_last), .matrix_A(t_matrix_A), .matrix_B(t_matrix_B),
    .start(t_start), .result_ready(t_rr), .busy(t_busy),
    .frame_error(t_frame_error), .timeout(t_timeout));

  always #5 clk = ~clk;

  // Event counters sampled on the active edge (value held during the cycle).
  always @(posedge clk) begin
    if (start === 1'b1) start_cnt++;
    if (frame_error === 1'b1) fe_cnt++;
    if (t_timeout === 1'b1) t_to_cnt++;
  end

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; result_ready = 1'b0;
    t_valid = 1'b0; t_last = 1'b0; t_rr = 1'b0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Present one element and return at the negedge after it was accepted.
  task automatic send(input logic [15:0] d, input logic last, input logic sel);
    int i;
    in_data = d;
    if (sel) begin t_valid = 1'b1; t_last = last; end
    else begin in_valid = 1'b1; in_last = last; end
    i = 0;
    while (((sel ? t_in_ready : in_ready) !== 1'b1) && i < 40) begin
      @(negedge clk); i++;
    end
    if ((sel ? t_in_ready : in_ready) !== 1'b1) begin
      tests++; failed++;
      $display("FAIL send_handshake in_ready=%b want 1", sel ? t_in_ready : in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; t_valid = 1'b0; t_last = 1'b0;
  endtask

  task automatic pulse_rr();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic bad;
    do_reset();
    bad = 1'b0;
    for (int i = 0; i < 4; i++) if (matrix_A[i] !== 16'd0 || matrix_B[i] !== 16'd0) bad = 1'b1;
    tests++;
    if (bad) begin failed++; $display("FAIL reset_arrays got nonzero want all 0"); end
    tests++;
    if ({start, busy, frame_error, timeout, in_ready} !== 5'b00001) begin
      failed++;
      $display("FAIL reset_ctrl got start/busy/fe/to/rdy=%b want 00001",
               {start, busy, frame_error, timeout, in_ready});
    end
  endtask

  task automatic test_stream();
    logic bad;
    int s0;
    do_reset();
    s0 = start_cnt;
    for (int k = 0; k < 8; k++) send(16'(k + 1), (k == 7), 1'b0);
    tests++;
    if ({start, busy, in_ready} !== 3'b110) begin
      failed++; $display("FAIL stream_fire got start/busy/rdy=%b want 110", {start, busy, in_ready});
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++)
      if (matrix_A[i] !== 16'(i + 1) || matrix_B[i] !== 16'(i + 5)) bad = 1'b1;
    tests++;
    if (bad) begin
      failed++;
      $display("FAIL stream_arrays got A0=%0d A3=%0d B0=%0d B3=%0d want 1 4 5 8",
               matrix_A[0], matrix_A[3], matrix_B[0], matrix_B[3]);
    end
    // start at cycle s; result_ready held during cycle s+10
    bad = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (start !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    @(negedge clk);
    tests++;
    if (bad || in_ready !== 1'b0) begin
      failed++; $display("FAIL stream_wait got start/ready/busy off-pattern want start=0 rdy=0 busy=1");
    end
    pulse_rr();
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failed++; $display("FAIL stream_release got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
    tests++;
    if (start_cnt - s0 !== 1) begin
      failed++; $display("FAIL stream_start_count got %0d want 1", start_cnt - s0);
    end
  endtask

  task automatic test_toggle();
    logic bad;
    int s0;
    do_reset();
    s0 = start_cnt;
    for (int k = 0; k < 8; k++) begin
      send(16'(k + 1), (k == 7), 1'b0);
      if (k < 7) @(negedge clk);
    end
    tests++;
    if (start !== 1'b1 || start_cnt != s0) begin
      failed++; $display("FAIL toggle_start got start=%b early=%0d want 1 0", start, start_cnt - s0);
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++)
      if (matrix_A[i] !== 16'(i + 1) || matrix_B[i] !== 16'(i + 5)) bad = 1'b1;
    tests++;
    if (bad) begin
      failed++; $display("FAIL toggle_arrays got A3=%0d B3=%0d want 4 8", matrix_A[3], matrix_B[3]);
    end
    @(negedge clk);
    pulse_rr();
  endtask

  task automatic test_frame_error();
    logic bad;
    int f0, s0;
    do_reset();
    f0 = fe_cnt; s0 = start_cnt;
    for (int k = 0; k < 6; k++) send(16'(k + 1), 1'b0, 1'b0);
    send(16'd7, 1'b1, 1'b0);
    tests++;
    if ({frame_error, start, in_ready} !== 3'b101 || matrix_B[2] !== 16'd0) begin
      failed++;
      $display("FAIL ferr_early got fe/start/rdy=%b B2=%0d want 101 0",
               {frame_error, start, in_ready}, matrix_B[2]);
    end
    @(negedge clk);
    for (int k = 0; k < 8; k++) send(16'(k + 9), (k == 7), 1'b0);
    tests++;
    if (start !== 1'b1 || fe_cnt - f0 !== 1 || start_cnt != s0) begin
      failed++;
      $display("FAIL ferr_recover got start=%b fe_cnt=%0d want 1 1", start, fe_cnt - f0);
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++)
      if (matrix_A[i] !== 16'(i + 9) || matrix_B[i] !== 16'(i + 13)) bad = 1'b1;
    tests++;
    if (bad) begin
      failed++; $display("FAIL ferr_arrays got A0=%0d B3=%0d want 9 16", matrix_A[0], matrix_B[3]);
    end
    @(negedge clk);
    pulse_rr();
  endtask

  task automatic test_missing_last();
    int s0;
    do_reset();
    s0 = start_cnt;
    for (int k = 0; k < 8; k++) send(16'(k + 1), 1'b0, 1'b0);
    tests++;
    if ({frame_error, start, in_ready} !== 3'b101 || matrix_B[3] !== 16'd8) begin
      failed++;
      $display("FAIL nolast got fe/start/rdy=%b B3=%0d want 101 8",
               {frame_error, start, in_ready}, matrix_B[3]);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (start_cnt != s0 || frame_error !== 1'b0) begin
      failed++; $display("FAIL nolast_quiet got starts=%0d fe=%b want 0 0", start_cnt - s0, frame_error);
    end
  endtask

  task automatic test_timeout();
    logic bad;
    int c0;
    do_reset();
    c0 = t_to_cnt;
    for (int k = 0; k < 8; k++) send(16'(k + 1), (k == 7), 1'b1);
    tests++;
    if (t_start !== 1'b1) begin failed++; $display("FAIL to_start got %b want 1", t_start); end
    bad = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      if (t_timeout !== 1'b0 || t_in_ready !== 1'b0) bad = 1'b1;
    end
    @(negedge clk);
    tests++;
    if (bad || t_timeout !== 1'b1 || t_in_ready !== 1'b1 || t_busy !== 1'b0) begin
      failed++;
      $display("FAIL to_expire got early=%b to=%b rdy=%b busy=%b want 0 1 1 0",
               bad, t_timeout, t_in_ready, t_busy);
    end
    @(negedge clk);
    // Second frame: result_ready lands in the expiry cycle (start+7).
    c0 = t_to_cnt;
    for (int k = 0; k < 8; k++) send(16'(k + 1), (k == 7), 1'b1);
    repeat (7) @(negedge clk);
    t_rr = 1'b1;
    @(negedge clk);
    t_rr = 1'b0;
    tests++;
    if (t_timeout !== 1'b0 || t_in_ready !== 1'b1) begin
      failed++; $display("FAIL to_rr_wins got to=%b rdy=%b want 0 1", t_timeout, t_in_ready);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (t_to_cnt != c0) begin
      failed++; $display("FAIL to_rr_count got %0d want 0", t_to_cnt - c0);
    end
  endtask

  task automatic test_async_reset();
    logic bad;
    int s0;
    do_reset();
    s0 = start_cnt;
    for (int k = 0; k < 7; k++) send(16'(k + 1), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (matrix_A[0] !== 16'd0 || matrix_B[0] !== 16'd0 || in_ready !== 1'b1 ||
        busy !== 1'b0 || start !== 1'b0) begin
      failed++;
      $display("FAIL areset_now got A0=%0d B0=%0d rdy=%b busy=%b want 0 0 1 0",
               matrix_A[0], matrix_B[0], in_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (start_cnt != s0) begin
      failed++; $display("FAIL areset_nostart got %0d want 0", start_cnt - s0);
    end
    for (int k = 0; k < 8; k++) send(16'(k + 21), (k == 7), 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++)
      if (matrix_A[i] !== 16'(i + 21) || matrix_B[i] !== 16'(i + 25)) bad = 1'b1;
    tests++;
    if (bad || start !== 1'b1) begin
      failed++; $display("FAIL areset_next got start=%b A0=%0d B3=%0d want 1 21 28",
                         start, matrix_A[0], matrix_B[3]);
    end
    @(negedge clk);
    pulse_rr();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_toggle();
    test_frame_error();
    test_missing_last();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
